// File: rtl/deploy_scheduler_pkg.sv
// Shared definitions for the deploy scheduler: scheduler FSM encodings,
// army type IDs and the number of deployable types.
package deploy_scheduler_pkg;

    localparam int N_TYPES = 8;

    localparam logic [1:0] DS_IDLE   = 2'd0;
    localparam logic [1:0] DS_OFFER  = 2'd1;
    localparam logic [1:0] DS_COMMIT = 2'd2;

    typedef enum logic [2:0] {
        KILLER_BIRD  = 3'd0,
        WHITE_BEAR   = 3'd1,
        METAL_DUCK   = 3'd2,
        BLACK_BEAR   = 3'd3,
        FIRE_ANT     = 3'd4,
        IRON_GOLEM   = 3'd5,
        WIND_HAWK    = 3'd6,
        STONE_TURTLE = 3'd7
    } army_t;

endpackage

// File: rtl/deploy_stats_rom.sv
// Combinational army stats table: type ID to deploy cost and cooldown reload
// (cooldown in game ticks; 0 means the type never cools).
module deploy_stats_rom
    import deploy_scheduler_pkg::*;
#(
    parameter int CD_W   = 8,
    parameter int COST_W = 15
) (
    input  logic [2:0]        army,
    output logic [COST_W-1:0] cost,
    output logic [CD_W-1:0]   cd_init
);

    always_comb begin
        cost    = '0;
        cd_init = '0;
        case (army)
            KILLER_BIRD:  begin cost = COST_W'(50);  cd_init = CD_W'(2);  end
            WHITE_BEAR:   begin cost = COST_W'(100); cd_init = CD_W'(5);  end
            METAL_DUCK:   begin cost = COST_W'(75);  cd_init = CD_W'(4);  end
            BLACK_BEAR:   begin cost = COST_W'(120); cd_init = CD_W'(6);  end
            FIRE_ANT:     begin cost = COST_W'(60);  cd_init = CD_W'(3);  end
            IRON_GOLEM:   begin cost = COST_W'(200); cd_init = CD_W'(8);  end
            WIND_HAWK:    begin cost = COST_W'(150); cd_init = CD_W'(0);  end
            STONE_TURTLE: begin cost = COST_W'(300); cd_init = CD_W'(10); end
            default:      begin cost = '0;           cd_init = '0;        end
        endcase
    end

endmodule

// File: rtl/deploy_scheduler.sv
// Latches army button clicks, picks one affordable request round-robin, offers it
// to the engine and debits its cost. Per-type cooldowns are built with DEPLOY_CD_EN.
module deploy_scheduler #(
    parameter int N_TYPES = deploy_scheduler_pkg::N_TYPES,
    parameter int CD_W    = 8,
    parameter int COST_W  = 15
) (
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic               game_init,
    input  logic               tick,
    input  logic [N_TYPES-1:0] req,
    input  logic [COST_W-1:0]  money,
    output logic               spawn_valid,
    output logic [2:0]         spawn_type,
    input  logic               spawn_ready,
    output logic               debit_valid,
    output logic [COST_W-1:0]  debit_amount,
    output logic [N_TYPES-1:0] pending,
    output logic [N_TYPES-1:0] cd_busy
);
    import deploy_scheduler_pkg::DS_IDLE;
    import deploy_scheduler_pkg::DS_OFFER;
    import deploy_scheduler_pkg::DS_COMMIT;

    logic [1:0]         state;
    logic [2:0]         rr;
    logic [2:0]         pick;
    logic [2:0]         idx;
    logic               any_elig;
    logic               commit;
    logic [N_TYPES-1:0] elig;
    logic [N_TYPES-1:0] accept;
    logic [N_TYPES-1:0] pending_next;
    logic [COST_W-1:0]  cost    [N_TYPES];
    logic [CD_W-1:0]    cd_init [N_TYPES];

    assign commit = (state == DS_COMMIT);

    for (genvar k = 0; k < N_TYPES; k++) begin : g_type
        deploy_stats_rom #(
            .CD_W   (CD_W),
            .COST_W (COST_W)
        ) u_rom (
            .army    (3'(k)),
            .cost    (cost[k]),
            .cd_init (cd_init[k])
        );
        assign elig[k] = pending[k] && (money >= cost[k]);
    end

    // Scan starts at rr so the type after the last one served gets first claim.
    always_comb begin
        any_elig = 1'b0;
        pick     = rr;
        idx      = rr;
        for (int i = 0; i < N_TYPES; i++) begin
            idx = rr + 3'(i);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                pick     = idx;
            end
        end
    end

`ifdef DEPLOY_CD_EN
    logic [CD_W-1:0] cd [N_TYPES];

    // The commit reload wins over a tick landing in the same cycle.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TYPES; k++) cd[k] <= '0;
        end else if (game_init) begin
            for (int k = 0; k < N_TYPES; k++) cd[k] <= '0;
        end else begin
            for (int k = 0; k < N_TYPES; k++) begin
                if (commit && (spawn_type == 3'(k)))
                    cd[k] <= cd_init[k];
                else if (tick && (cd[k] != '0))
                    cd[k] <= cd[k] - CD_W'(1);
            end
        end
    end

    for (genvar k = 0; k < N_TYPES; k++) begin : g_cd
        assign cd_busy[k] = (cd[k] != '0);
        assign accept[k]  = req[k] && (cd[k] == '0);
    end
`else
    logic unused_cd;

    assign cd_busy = '0;
    assign accept  = req & ~pending;

    always_comb begin
        unused_cd = tick;
        for (int k = 0; k < N_TYPES; k++) unused_cd = unused_cd ^ (^cd_init[k]);
    end
`endif

    // A click on the type being committed this cycle is lost: the clear wins.
    always_comb begin
        pending_next = pending | accept;
        if (commit) pending_next[spawn_type] = 1'b0;
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n)         pending <= '0;
        else if (game_init) pending <= '0;
        else                pending <= pending_next;
    end

    // Handshake: spawn_type is held while spawn_valid is high; the spawn transfers on
    // the cycle spawn_valid && spawn_ready, and debit_valid pulses in the next cycle.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= DS_IDLE;
            rr           <= '0;
            spawn_valid  <= 1'b0;
            spawn_type   <= '0;
            debit_valid  <= 1'b0;
            debit_amount <= '0;
        end else if (game_init) begin
            state        <= DS_IDLE;
            rr           <= '0;
            spawn_valid  <= 1'b0;
            spawn_type   <= '0;
            debit_valid  <= 1'b0;
            debit_amount <= '0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (any_elig) begin
                        spawn_type  <= pick;
                        spawn_valid <= 1'b1;
                        state       <= DS_OFFER;
                    end
                end
                DS_OFFER: begin
                    if (spawn_ready) begin
                        spawn_valid  <= 1'b0;
                        debit_valid  <= 1'b1;
                        debit_amount <= cost[spawn_type];
                        state        <= DS_COMMIT;
                    end else if (money < cost[spawn_type]) begin
                        spawn_valid <= 1'b0;
                        state       <= DS_IDLE;
                    end
                end
                DS_COMMIT: begin
                    debit_valid  <= 1'b0;
                    debit_amount <= '0;
                    rr           <= spawn_type + 3'd1;
                    state        <= DS_IDLE;
                end
                default: begin
                    spawn_valid <= 1'b0;
                    state       <= DS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deploy_scheduler.sv
// Directed bench for deploy_scheduler: request latch, offer/commit handshake,
// round-robin order, affordability withdraw, abort and cooldown behaviour.
module tb_deploy_scheduler;

    logic        clk_25MHz = 1'b0;
    logic        rst_n;
    logic        game_init;
    logic        tick;
    logic [7:0]  req;
    logic [14:0] money;
    logic        spawn_valid;
    logic [2:0]  spawn_type;
    logic        spawn_ready;
    logic        debit_valid;
    logic [14:0] debit_amount;
    logic [7:0]  pending;
    logic [7:0]  cd_busy;

    int checks   = 0;
    int failures = 0;

    always #20 clk_25MHz = ~clk_25MHz;

    deploy_scheduler dut (
        .clk_25MHz    (clk_25MHz),
        .rst_n        (rst_n),
        .game_init    (game_init),
        .tick         (tick),
        .req          (req),
        .money        (money),
        .spawn_valid  (spawn_valid),
        .spawn_type   (spawn_type),
        .spawn_ready  (spawn_ready),
        .debit_valid  (debit_valid),
        .debit_amount (debit_amount),
        .pending      (pending),
        .cd_busy      (cd_busy)
    );

    task automatic cyc();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_spawn_valid"},  32'(spawn_valid),  32'd0);
        chk({tag, "_spawn_type"},   32'(spawn_type),   32'd0);
        chk({tag, "_debit_valid"},  32'(debit_valid),  32'd0);
        chk({tag, "_debit_amount"}, 32'(debit_amount), 32'd0);
        chk({tag, "_pending"},      32'(pending),      32'd0);
        chk({tag, "_cd_busy"},      32'(cd_busy),      32'd0);
    endtask

    // Waits (bounded) for an offer, checks its type, accepts it and checks the debit.
    task automatic serve(input string tag, input logic [2:0] t, input logic [14:0] c);
        int n;
        n = 0;
        while (!spawn_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_offer"}, 32'(spawn_valid), 32'd1);
        chk({tag, "_type"},  32'(spawn_type),  32'(t));
        spawn_ready = 1'b1;
        cyc();
        spawn_ready = 1'b0;
        chk({tag, "_debit_valid"},  32'(debit_valid),  32'd1);
        chk({tag, "_debit_amount"}, 32'(debit_amount), 32'(c));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        game_init   = 1'b0;
        tick        = 1'b0;
        req         = '0;
        money       = 15'd500;
        spawn_ready = 1'b0;
        #5;
        chk_reset_outputs("reset");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_no_offer", 32'(spawn_valid), 32'd0);

        // Lone request for White_Bear (cost 100, cooldown 5)
        req = 8'h02;
        cyc();
        req = '0;
        chk("lone_pending", 32'(pending), 32'h02);
        chk("lone_not_yet_valid", 32'(spawn_valid), 32'd0);
        cyc();
        chk("lone_valid", 32'(spawn_valid), 32'd1);
        chk("lone_type", 32'(spawn_type), 32'd1);
        spawn_ready = 1'b1;
        cyc();
        spawn_ready = 1'b0;
        chk("lone_valid_drops", 32'(spawn_valid), 32'd0);
        chk("lone_debit_valid", 32'(debit_valid), 32'd1);
        chk("lone_debit_amount", 32'(debit_amount), 32'd100);
        cyc();
        chk("lone_debit_done", 32'(debit_valid), 32'd0);
        chk("lone_debit_zero", 32'(debit_amount), 32'd0);
        chk("lone_pending_clr", 32'(pending), 32'd0);
`ifdef DEPLOY_CD_EN
        chk("lone_cd_busy", 32'(cd_busy), 32'h02);
        pulse_tick();
        req = 8'h02;
        pulse_tick();
        req = '0;
        chk("cd_drop_pending", 32'(pending), 32'd0);
        chk("cd_drop_busy", 32'(cd_busy), 32'h02);
        pulse_tick();
        pulse_tick();
        chk("cd_tick4_busy", 32'(cd_busy), 32'h02);
        pulse_tick();
        chk("cd_tick5_clear", 32'(cd_busy), 32'd0);
`else
        chk("lone_cd_busy", 32'(cd_busy), 32'd0);
`endif
        req = 8'h02;
        cyc();
        req = '0;
        chk("rereq_pending", 32'(pending), 32'h02);
        serve("rereq", 3'd1, 15'd100);

        // Clear everything so the round-robin pointer restarts at 0
        game_init = 1'b1;
        cyc();
        game_init = 1'b0;
        chk("init_pending", 32'(pending), 32'd0);
        chk("init_cd_busy", 32'(cd_busy), 32'd0);

        // Round-robin over types 0, 3, 5
        req = 8'h29;
        cyc();
        req = '0;
        chk("rr_pending", 32'(pending), 32'h29);
        serve("rr_a", 3'd0, 15'd50);
        serve("rr_b", 3'd3, 15'd120);
        serve("rr_c", 3'd5, 15'd200);
        for (int i = 0; i < 8; i++) pulse_tick();
        chk("rr_cd_clear", 32'(cd_busy), 32'd0);
        req = 8'h21;
        cyc();
        req = '0;
        serve("rr_wrap_a", 3'd0, 15'd50);
        serve("rr_wrap_b", 3'd5, 15'd200);
        // rr is now 6: type 7 must beat type 0
        pulse_tick();
        pulse_tick();
        req = 8'h81;
        cyc();
        req = '0;
        serve("rr_pri_a", 3'd7, 15'd300);
        serve("rr_pri_b", 3'd0, 15'd50);
        chk("rr_pending_empty", 32'(pending), 32'd0);

        // Affordability: Metal_Duck costs 75
        money = 15'd50;
        req = 8'h04;
        cyc();
        req = '0;
        chk("afford_pending", 32'(pending), 32'h04);
        cyc();
        cyc();
        cyc();
        chk("afford_no_offer", 32'(spawn_valid), 32'd0);
        money = 15'd75;
        cyc();
        chk("afford_offer", 32'(spawn_valid), 32'd1);
        chk("afford_type", 32'(spawn_type), 32'd2);
        money = 15'd40;
        cyc();
        chk("withdraw_valid", 32'(spawn_valid), 32'd0);
        chk("withdraw_no_debit", 32'(debit_valid), 32'd0);
        chk("withdraw_pending", 32'(pending), 32'h04);
        cyc();
        chk("withdraw_stays", 32'(spawn_valid), 32'd0);

        // Stall then abort with game_init
        money = 15'd500;
        cyc();
        chk("stall_offer", 32'(spawn_valid), 32'd1);
        chk("stall_type0", 32'(spawn_type), 32'd2);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_valid", 32'(spawn_valid), 32'd1);
            chk("stall_type", 32'(spawn_type), 32'd2);
        end
        game_init = 1'b1;
        cyc();
        game_init = 1'b0;
        chk_reset_outputs("abort");
        cyc();
        chk("abort_no_debit", 32'(debit_valid), 32'd0);
        chk("abort_no_offer", 32'(spawn_valid), 32'd0);

        // Tick coincides with the COMMIT of Fire_Ant (cooldown 3)
        req = 8'h10;
        cyc();
        req = '0;
        cyc();
        chk("coll_offer", 32'(spawn_valid), 32'd1);
        chk("coll_type", 32'(spawn_type), 32'd4);
        spawn_ready = 1'b1;
        cyc();
        spawn_ready = 1'b0;
        chk("coll_debit_amount", 32'(debit_amount), 32'd60);
        tick = 1'b1;
        req  = 8'h10;
        cyc();
        tick = 1'b0;
        req  = '0;
        chk("coll_req_dropped", 32'(pending), 32'd0);
`ifdef DEPLOY_CD_EN
        chk("coll_cd_loaded", 32'(cd_busy), 32'h10);
        pulse_tick();
        pulse_tick();
        chk("coll_cd_after2", 32'(cd_busy), 32'h10);
        pulse_tick();
        chk("coll_cd_after3", 32'(cd_busy), 32'd0);
`else
        chk("coll_cd_none", 32'(cd_busy), 32'd0);
`endif
        cyc();
        chk("final_idle", 32'(spawn_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
